axis_rr_packet_arbiter: RTL and testbench
=========================================

AXIS_RR_PACKET_ARBITER -- requirements
Module: axis_rr_packet_arbiter

Interface
REQ-001 Parameter NUM, default 4, number of slave streams; legal range 2..16.
REQ-002 Parameter DSIZE, default 8, tdata width in bits.
REQ-003 Parameter USIZE, default 1, tuser width in bits.
REQ-004 aclk  in  1  sole clock; all logic rising-edge.
REQ-005 areset  in  1  reset, synchronous, active-high.
REQ-006 s_tdata  in  NUM*DSIZE  slave data; port k occupies bits [k*DSIZE +: DSIZE].
REQ-007 s_tuser  in  NUM*USIZE  slave user; port k occupies bits [k*USIZE +: USIZE].
REQ-008 s_tvalid  in  NUM  per-port valid.
REQ-009 s_tlast  in  NUM  per-port end-of-packet.
REQ-010 s_tready  out  NUM  per-port ready.
REQ-011 m_tdata / m_tuser / m_tvalid / m_tlast  out  DSIZE / USIZE / 1 / 1  merged master stream.
REQ-012 m_tready  in  1  master ready.
REQ-013 grant  out  NUM  one-hot current owner; all-zero when idle.
REQ-014 busy  out  1  high while a packet is locked.

Function
REQ-015 FSM states: IDLE, LOCK.
REQ-016 IDLE: if any s_tvalid is high, the first valid port at or after pointer ptr (wrapping NUM-1 to 0) is latched into grant and the FSM moves to LOCK on the next edge; otherwise it stays in IDLE.
REQ-017 In IDLE all s_tready are 0 and m_tvalid is 0 (path without output register).
REQ-018 LOCK: the granted port's tdata/tuser/tlast/tvalid are forwarded to the master; s_tready[g] = m_tready; all other s_tready are 0.
REQ-019 grant is held constant throughout LOCK and changes only on the IDLE->LOCK transition.
REQ-020 On a handshake (s_tvalid[g] & s_tready[g]) with s_tlast[g]=1: FSM -> IDLE, ptr <= (g+1) mod NUM.
REQ-021 Mid-packet valid gaps on the granted port do not release the grant.
REQ-022 Requests from non-granted ports during LOCK are ignored; those ports are never dropped and wait for IDLE.
REQ-023 A single-beat packet (tlast on its first beat) takes one LOCK cycle plus one IDLE arbitration cycle.
REQ-024 Arbitration costs exactly one bubble cycle per packet; maximum throughput is L/(L+1) for L-beat packets.
REQ-025 Fairness: with all NUM ports continuously requesting, grants rotate 0,1,...,NUM-1,0 with no port served twice before every other port is served once.
REQ-026 busy = (state == LOCK).

Reset
REQ-027 areset sampled high: state=IDLE, grant=0, ptr=0, busy=0, all s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0; the output register (if present) is emptied.
REQ-028 Reset asserted mid-packet aborts the packet; the remaining beats are not forwarded, and after reset port 0 has the highest priority.

Configuration
REQ-029 Macro AXIS_RR_ARB_OUTREG_EN, when defined, inserts a 2-entry skid register on the master side.
REQ-030 With the macro defined: master outputs are registered, latency is +1 cycle, s_tready[g] = skid not full, full throughput holds under m_tready backpressure, and no beat is lost or duplicated.
REQ-031 With the macro defined: the FSM leaves LOCK when the tlast beat is accepted into the skid, not when it exits the skid.
REQ-032 Without the macro: the master path is purely combinational from the granted port, with zero added latency.

Verification
REQ-033 Reset, then only port 2 sends a 3-beat packet (0xA1,0xA2,0xA3), m_tready=1 -> grant=4'b0100 one cycle after valid; master emits A1,A2,A3 with tlast on A3; grant=0 afterwards; ptr=3.
REQ-034 All 4 ports hold 2-beat packets continuously -> packet owner sequence 0,1,2,3,0,1; one idle cycle between packets; no interleaving of beats from different ports.
REQ-035 Port 1 is granted and m_tready toggles 1,0,1,0 over a 4-beat packet -> each beat appears exactly once and in order; the other ports' s_tready stay 0; grant stays 4'b0010 until tlast.
REQ-036 Port 0 deasserts tvalid for 5 cycles mid-packet while port 3 requests -> grant stays on port 0 until its tlast, then port 3 is granted.
REQ-037 areset pulsed during beat 2 of a 4-beat packet on port 1 -> all outputs match REQ-027 the next cycle; a new request on port 1 is granted afresh with ptr=0 priority order.
REQ-038 With AXIS_RR_ARB_OUTREG_EN defined, m_tready=1 and single-beat packets on ports 0 and 1 -> the first beat appears on the master 2 cycles after valid, and the data matches the non-registered build delayed by 1 cycle.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin packet arbiter for AXI-Stream.
// Merges NUM slave streams into one master stream. A port keeps the grant
// from its first beat until its tlast beat is accepted; the next search
// starts at the port after the one just served.
// Build option: define AXIS_RR_ARB_OUTREG_EN to put a 2-entry skid
// register on the master side (registered outputs, +1 cycle latency).
module axis_rr_packet_arbiter #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int USIZE = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM*DSIZE-1:0]  s_tdata,
  input  logic [NUM*USIZE-1:0]  s_tuser,
  input  logic [NUM-1:0]        s_tvalid,
  input  logic [NUM-1:0]        s_tlast,
  output logic [NUM-1:0]        s_tready,
  output logic [DSIZE-1:0]      m_tdata,
  output logic [USIZE-1:0]      m_tuser,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [NUM-1:0]        grant,
  output logic                  busy
);

  localparam int IW = $clog2(NUM);
  localparam int CW = IW + 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [NUM-1:0]  grant_reg, grant_next;
  logic [IW-1:0]   gidx_reg, gidx_next;
  logic [IW-1:0]   ptr_reg, ptr_next;

  logic [DSIZE-1:0] data_arr [NUM];
  logic [USIZE-1:0] user_arr [NUM];

  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic [CW-1:0]    cand;

  logic             g_valid, g_last, g_ready, accept;
  logic [DSIZE-1:0] g_data;
  logic [USIZE-1:0] g_user;

  // Unpack the flat slave buses into per-port lanes
  for (genvar gi = 0; gi < NUM; gi++) begin : g_split
    assign data_arr[gi] = s_tdata[gi*DSIZE +: DSIZE];
    assign user_arr[gi] = s_tuser[gi*USIZE +: USIZE];
  end

  // Signals of the currently granted port
  assign g_valid = s_tvalid[gidx_reg];
  assign g_last  = s_tlast[gidx_reg];
  assign g_data  = data_arr[gidx_reg];
  assign g_user  = user_arr[gidx_reg];

  // A beat leaves the granted slave this cycle
  assign accept = (state_reg == LOCK) & g_valid & g_ready;

  // Pick the first requesting port at or after ptr, wrapping at NUM
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM; i++) begin
      cand = {1'b0, ptr_reg} + CW'(i);
      if (cand >= CW'(NUM)) cand = cand - CW'(NUM);
      if (!sel_found && s_tvalid[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  // State, grant and pointer registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Next-state: lock onto a requester, release after its tlast beat
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = LOCK;
          grant_next = NUM'(1) << sel_idx;
          gidx_next  = sel_idx;
        end
      end
      LOCK: begin
        if (accept && g_last) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = (gidx_reg == IW'(NUM-1)) ? '0 : gidx_reg + IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef AXIS_RR_ARB_OUTREG_EN
  localparam int BW = DSIZE + USIZE + 1;

  logic [BW-1:0] skid_mem [2];
  logic          skid_wr_reg, skid_rd_reg;
  logic [1:0]    skid_cnt_reg;
  logic          skid_push, skid_pop;
  logic [BW-1:0] skid_head;

  // The slave sees ready whenever the skid has a free slot, so the tlast
  // beat can release the lock while earlier beats still wait downstream.
  assign g_ready   = (skid_cnt_reg != 2'd2);
  assign skid_push = accept;
  assign skid_pop  = (skid_cnt_reg != 2'd0) & m_tready;
  assign skid_head = skid_mem[skid_rd_reg];

  // Two-entry skid FIFO between the granted slave and the master
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
      skid_wr_reg  <= 1'b0;
      skid_rd_reg  <= 1'b0;
      skid_cnt_reg <= 2'd0;
    end else begin
      if (skid_push) begin
        skid_mem[skid_wr_reg] <= {g_data, g_user, g_last};
        skid_wr_reg           <= ~skid_wr_reg;
      end
      if (skid_pop) skid_rd_reg <= ~skid_rd_reg;
      case ({skid_push, skid_pop})
        2'b10:   skid_cnt_reg <= skid_cnt_reg + 2'd1;
        2'b01:   skid_cnt_reg <= skid_cnt_reg - 2'd1;
        default: skid_cnt_reg <= skid_cnt_reg;
      endcase
    end
  end
`else
  assign g_ready = m_tready;
`endif

  // Outputs: ready only to the owner, master fed from owner or skid
  always_comb begin
    s_tready = '0;
    if (state_reg == LOCK) s_tready[gidx_reg] = g_ready;
`ifdef AXIS_RR_ARB_OUTREG_EN
    m_tvalid = (skid_cnt_reg != 2'd0);
    {m_tdata, m_tuser, m_tlast} = skid_head;
`else
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tuser  = '0;
    m_tlast  = 1'b0;
    if (state_reg == LOCK) begin
      m_tvalid = g_valid;
      m_tdata  = g_data;
      m_tuser  = g_user;
      m_tlast  = g_last;
    end
`endif
  end

  assign grant = grant_reg;
  assign busy  = (state_reg == LOCK);

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Randomized bench for axis_rr_packet_arbiter (default build).
// A packet-level model tracks the current owner and the round-robin
// pointer; per-port beat lists supply both the stimulus and the
// expected master data.
module tb_axis_rr_packet_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int USIZE = 1;

  logic                 aclk = 1'b0;
  logic                 areset;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM*USIZE-1:0] s_tuser;
  logic [NUM-1:0]       s_tvalid;
  logic [NUM-1:0]       s_tlast;
  logic [NUM-1:0]       s_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic [USIZE-1:0]     m_tuser;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;
  logic [NUM-1:0]       grant;
  logic                 busy;

  always #5 aclk = ~aclk;

  axis_rr_packet_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .USIZE(USIZE)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [DSIZE-1:0] d;
    logic [USIZE-1:0] u;
    logic             l;
  } beat_t;

  beat_t pkt_mem [NUM][256];
  int    rd_idx [NUM];
  int    wr_idx [NUM];

  int    owner;        // model: port holding the grant, -1 when idle
  int    ptr;          // model: round-robin search start
  bit    refill;
  int    fixed_len;
  bit    fair_mode;
  int    last_rr;
  logic [NUM-1:0] prev_grant;
  int    n_checks;
  int    n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic gen_packet(input int p, input int len);
    beat_t b;
    logic [7:0] pv;
    pv = 8'(p);
    if (rd_idx[p] == wr_idx[p]) begin
      rd_idx[p] = 0;
      wr_idx[p] = 0;
    end
    for (int i = 0; i < len; i++) begin
      b.d = {pv[1:0], 6'($urandom)};
      b.u = USIZE'($urandom);
      b.l = (i == len - 1);
      pkt_mem[p][wr_idx[p]] = b;
      wr_idx[p]++;
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (owner < 0);
    for (int p = 0; p < NUM; p++) if (rd_idx[p] != wr_idx[p]) r = 1'b0;
    return r;
  endfunction

  // One clock: drive after the edge, check and advance the model mid-cycle
  task automatic step(input int vpct, input int rpct, input bit rst);
    logic [NUM-1:0] exp_rdy;
    bit   hs, found;
    int   gi_dut, q;
    beat_t b;
    @(posedge aclk);
    #1;
    areset   = rst;
    m_tready = ($urandom_range(99) < rpct);
    for (int p = 0; p < NUM; p++) begin
      if (refill && rd_idx[p] == wr_idx[p])
        gen_packet(p, (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4)));
      if (rd_idx[p] != wr_idx[p]) begin
        b = pkt_mem[p][rd_idx[p]];
        s_tvalid[p] = ($urandom_range(99) < vpct);
        s_tdata[p*DSIZE +: DSIZE] = b.d;
        s_tuser[p*USIZE +: USIZE] = b.u;
        s_tlast[p] = b.l;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tdata[p*DSIZE +: DSIZE] = '0;
        s_tuser[p*USIZE +: USIZE] = '0;
        s_tlast[p] = 1'b0;
      end
    end
    @(negedge aclk);
    if (rst) begin
      owner = -1;
      ptr   = 0;
      for (int p = 0; p < NUM; p++) begin
        rd_idx[p] = 0;
        wr_idx[p] = 0;
      end
      return;
    end
    check("grant", 32'(grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
    check("busy", 32'(busy), 32'(owner >= 0));
    exp_rdy = '0;
    if (owner >= 0) exp_rdy[owner] = m_tready;
    check("s_tready", 32'(s_tready), 32'(exp_rdy));
    hs = (owner >= 0) && s_tvalid[owner];
    check("m_tvalid", 32'(m_tvalid), 32'(hs));
    if (fair_mode && prev_grant == '0 && grant != '0) begin
      gi_dut = 0;
      for (int i = 0; i < NUM; i++) if (grant[i]) gi_dut = i;
      if (last_rr >= 0) check("rr_order", 32'(gi_dut), 32'((last_rr + 1) % NUM));
      last_rr = gi_dut;
    end
    prev_grant = grant;
    if (hs && m_tready) begin
      b = pkt_mem[owner][rd_idx[owner]];
      check("m_tdata", 32'(m_tdata), 32'(b.d));
      check("m_tuser", 32'(m_tuser), 32'(b.u));
      check("m_tlast", 32'(m_tlast), 32'(b.l));
      rd_idx[owner]++;
      if (b.l) begin
        ptr   = (owner + 1) % NUM;
        owner = -1;
      end
    end else if (owner < 0) begin
      found = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        q = (ptr + i) % NUM;
        if (!found && s_tvalid[q]) begin
          found = 1'b1;
          owner = q;
        end
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    bit done;
    done = all_idle();
    for (int c = 0; c < budget && !done; c++) begin
      step(100, 100, 1'b0);
      done = all_idle();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    areset    = 1'b1;
    s_tvalid  = '0;
    s_tlast   = '0;
    s_tdata   = '0;
    s_tuser   = '0;
    m_tready  = 1'b0;
    owner     = -1;
    ptr       = 0;
    refill    = 1'b0;
    fixed_len = 0;
    fair_mode = 1'b0;
    last_rr   = -1;
    n_checks  = 0;
    n_pass    = 0;
    for (int p = 0; p < NUM; p++) begin
      rd_idx[p] = 0;
      wr_idx[p] = 0;
    end

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);

    // Random traffic with valid gaps and master backpressure
    refill = 1'b1;
    repeat (400) step(70, 70, 1'b0);

    // All ports continuously requesting 2-beat packets: strict rotation
    fixed_len  = 2;
    fair_mode  = 1'b1;
    last_rr    = -1;
    prev_grant = grant;
    repeat (60) step(100, 100, 1'b0);
    fair_mode  = 1'b0;
    fixed_len  = 0;

    // Reset in the middle of a packet on port 1 after ptr has moved to 1
    refill = 1'b0;
    drain(200, "drain_to_idle");
    gen_packet(0, 1);
    drain(50, "port0_single");
    gen_packet(1, 4);
    for (int c = 0; c < 50 && rd_idx[1] < 2; c++) step(100, 100, 1'b0);
    check("reach_beat2", 32'(rd_idx[1] >= 2), 32'd1);
    step(100, 100, 1'b1);
    step(0, 100, 1'b0);
    check("post_rst_m_tdata", 32'(m_tdata), 32'd0);
    check("post_rst_m_tuser", 32'(m_tuser), 32'd0);
    check("post_rst_m_tlast", 32'(m_tlast), 32'd0);
    check("post_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    gen_packet(0, 2);
    gen_packet(1, 2);
    step(100, 100, 1'b0);
    step(100, 100, 1'b0);
    check("post_rst_grant", 32'(grant), 32'd1);
    drain(50, "post_rst_drain");

    // More random traffic with heavier backpressure
    refill = 1'b1;
    repeat (300) step(60, 50, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
